// File: rtl/mux_arb_pkg.sv
// Shared types and default sizing for the round-robin mux arbiter.
package mux_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_e;

    localparam int unsigned DEF_N         = 16;
    localparam int unsigned DEF_SELW      = 4;
    localparam int unsigned DEF_MAX_BURST = 4;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester/flow-control bundle between the requesters and the mux arbiter.
interface mux_rr_arbiter_if
    import mux_arb_pkg::*;
#(
    parameter int unsigned N    = DEF_N,
    parameter int unsigned SELW = DEF_SELW
);
    logic [N-1:0]    req;
    logic [N-1:0]    req_last;
    logic            out_ready;
    logic [SELW-1:0] sel;
    logic [N-1:0]    gnt;
    logic            out_valid;
    logic            busy;

    // Requester/downstream side: drives requests and ready.
    modport master (
        output req, req_last, out_ready,
        input  sel, gnt, out_valid, busy
    );

    // Arbiter side.
    modport slave (
        input  req, req_last, out_ready,
        output sel, gnt, out_valid, busy
    );
endinterface

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set bit of req searching ptr, ptr+1, ... mod N.
module rr_pick #(
    parameter int unsigned N    = 16,
    parameter int unsigned SELW = 4
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic            any,
    output logic [SELW-1:0] idx
);
    localparam int NI = int'(N);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] masked;

    assign dbl = {req, req};

    // Drop doubled bits below ptr; any remaining bit in the upper copy covers the wrap.
    always_comb begin
        masked = '0;
        for (int j = 0; j < 2 * NI; j++) begin
            masked[j] = dbl[j] & (j >= int'(ptr));
        end
    end

    // Lowest set masked bit wins; scan downward so the last hit is the lowest.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int j = 2 * NI - 1; j >= 0; j--) begin
            if (masked[j]) begin
                any = 1'b1;
                idx = SELW'(j % NI);
            end
        end
    end
endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin burst arbiter driving the select of an N:1 data mux.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned N         = DEF_N,
    parameter int unsigned SELW      = DEF_SELW,
    parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
    input logic              clk,
    input logic              rst,
    mux_rr_arbiter_if.slave  bus
);
    localparam int unsigned CNTW = $clog2(MAX_BURST + 1);
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(MAX_BURST - 1);

    arb_state_e      state_q, state_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic            busy;
    logic            valid;
    logic            xfer;
    logic            rel;
    logic [SELW-1:0] sel_inc;
    logic [SELW-1:0] pick_ptr;
    logic            pick_any;
    logic [SELW-1:0] pick_idx;

    assign busy    = (state_q == ARB_BUSY);
    assign valid   = busy & bus.req[sel_q];
    assign xfer    = valid & bus.out_ready;
    assign sel_inc = sel_q + 1'b1;
    // Release on last beat, burst cap, or withdrawal (valid low means no transfer).
    assign rel     = (xfer & (bus.req_last[sel_q] | (cnt_q == LAST_CNT))) |
                     (busy & ~bus.req[sel_q]);
    // At release the releasing index becomes lowest priority.
    assign pick_ptr = busy ? sel_inc : ptr_q;

    rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_pick (
        .req (bus.req),
        .ptr (pick_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Next-state: grant from idle, count beats, release and re-arbitrate without a bubble.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                gnt_d = '0;
                if (pick_any) begin
                    state_d         = ARB_BUSY;
                    sel_d           = pick_idx;
                    gnt_d[pick_idx] = 1'b1;
                    cnt_d           = '0;
                end
            end
            ARB_BUSY: begin
                if (rel) begin
                    ptr_d = sel_inc;
                    cnt_d = '0;
                    gnt_d = '0;
                    if (pick_any) begin
                        sel_d           = pick_idx;
                        gnt_d[pick_idx] = 1'b1;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State, pointer, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.gnt       = gnt_q;
    assign bus.out_valid = valid;
    assign bus.busy      = busy;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter.
module tb_mux_rr_arbiter;
    localparam int unsigned N         = 16;
    localparam int unsigned SELW      = 4;
    localparam int unsigned MAX_BURST = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errs;

    mux_rr_arbiter_if #(.N(N), .SELW(SELW)) bus ();

    mux_rr_arbiter #(
        .N         (N),
        .SELW      (SELW),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Settle the current inputs, then compare all outputs.
    task automatic expect_out(input string tag, input int sel, input logic [15:0] gnt,
                              input logic ov, input logic bsy);
        #1;
        check_eq({tag, ".sel"}, 32'(bus.sel), 32'(sel));
        check_eq({tag, ".gnt"}, 32'(bus.gnt), 32'(gnt));
        check_eq({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
        check_eq({tag, ".busy"}, 32'(bus.busy), 32'(bsy));
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req       = '0;
        bus.req_last  = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errs   = 0;

        // Reset values, then reset in the middle of a second burst.
        do_reset();
        expect_out("rst_val", 0, 16'h0000, 1'b0, 1'b0);
        bus.req       = 16'hFFFF;
        bus.req_last  = 16'h0000;
        bus.out_ready = 1'b1;
        tick();
        expect_out("rst_g0", 0, 16'h0001, 1'b1, 1'b1);
        tick();
        tick();
        tick();
        tick();
        expect_out("rst_g1", 1, 16'h0002, 1'b1, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        expect_out("rst_mid", 0, 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        expect_out("rst_first", 0, 16'h0001, 1'b1, 1'b1);

        // Rotation between 0 and 4, one beat each, no idle cycles.
        do_reset();
        bus.req       = 16'h0011;
        bus.req_last  = 16'hFFFF;
        bus.out_ready = 1'b1;
        tick();
        for (int k = 0; k < 7; k++) begin
            expect_out("rot", (k % 2) ? 4 : 0, (k % 2) ? 16'h0010 : 16'h0001, 1'b1, 1'b1);
            tick();
        end
        // All requests drop: release to idle, sel holds.
        bus.req = 16'h0000;
        expect_out("rot_drop", 4, 16'h0010, 1'b0, 1'b1);
        tick();
        expect_out("idle_hold", 4, 16'h0000, 1'b0, 1'b0);

        // Burst cap: 4 beats each to 2 and 8.
        do_reset();
        bus.req       = 16'h0104;
        bus.req_last  = 16'h0000;
        bus.out_ready = 1'b1;
        tick();
        for (int k = 0; k < 12; k++) begin
            expect_out("burst", ((k / 4) % 2) ? 8 : 2,
                       ((k / 4) % 2) ? 16'h0100 : 16'h0004, 1'b1, 1'b1);
            tick();
        end

        // Backpressure on index 5: hold for 10 cycles, then exactly 4 beats.
        do_reset();
        bus.req       = 16'h0060;
        bus.req_last  = 16'h0000;
        bus.out_ready = 1'b0;
        tick();
        for (int k = 0; k < 10; k++) begin
            expect_out("bp_hold", 5, 16'h0020, 1'b1, 1'b1);
            tick();
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            expect_out("bp_beat", 5, 16'h0020, 1'b1, 1'b1);
            tick();
        end
        expect_out("bp_next", 6, 16'h0040, 1'b1, 1'b1);

        // Withdrawal of index 3: search restarts at 4, so 9 beats 1.
        do_reset();
        bus.req       = 16'h0208;
        bus.req_last  = 16'h0000;
        bus.out_ready = 1'b0;
        tick();
        expect_out("wd_g3", 3, 16'h0008, 1'b1, 1'b1);
        bus.req = 16'h0202;
        expect_out("wd_drop", 3, 16'h0008, 1'b0, 1'b1);
        tick();
        expect_out("wd_g9", 9, 16'h0200, 1'b1, 1'b1);

        // Wrap: release 14 sets ptr to 15; 15 wins, then 0.
        do_reset();
        bus.req       = 16'h4000;
        bus.req_last  = 16'hFFFF;
        bus.out_ready = 1'b1;
        tick();
        expect_out("wrap_g14", 14, 16'h4000, 1'b1, 1'b1);
        bus.req = 16'h8001;
        tick();
        expect_out("wrap_g15", 15, 16'h8000, 1'b1, 1'b1);
        tick();
        expect_out("wrap_g0", 0, 16'h0001, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
